mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: MAX_WAIT, 15, maximum cycles bus_req may stay unacknowledged before a timeout.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 mem_re  in  1  M-stage load request, held stable by the pipeline register while stall=1.
REQ-005 mem_we  in  1  M-stage store request; mem_re and mem_we are never both 1.
REQ-006 mem_size  in  2  access size: 0 byte, 1 half, 2 word; 3 is treated as word.
REQ-007 mem_signed  in  1  1 = sign-extend a sub-word load, 0 = zero-extend it.
REQ-008 mem_addr  in  32  byte address (ALU result).
REQ-009 mem_wdata  in  32  store data (forwarded RD2).
REQ-010 bus_ack  in  1  memory accepts the request; bus_rdata is valid in the same cycle.
REQ-011 bus_rdata  in  32  word read data.
REQ-012 bus_req  out  1  registered request to memory.
REQ-013 bus_we  out  1  registered write strobe; qualified by bus_req.
REQ-014 bus_addr  out  32  registered word address {mem_addr[31:2],2'b00}.
REQ-015 bus_be  out  4  registered byte enables.
REQ-016 bus_wdata  out  32  registered lane-replicated store data.
REQ-017 load_data  out  32  aligned and extended load result; valid while done=1.
REQ-018 done  out  1  one-cycle pulse: the access is complete and the pipeline may advance.
REQ-019 stall  out  1  combinational; 1 = freeze the F, D, E and M stages.
REQ-020 mem_err  out  1  one-cycle pulse coincident with done on a timeout or misalignment.

Function
REQ-021 The FSM SHALL have four states: IDLE, REQ, DONE, ERR.
REQ-022 In IDLE with mem_re|mem_we=1 and the access aligned, the FSM SHALL load the bus registers and enter REQ.
REQ-023 In REQ the block SHALL hold bus_req=1 with every bus output constant until the cycle in which bus_ack=1.
REQ-024 On bus_ack in REQ, the block SHALL capture the load result into load_data and enter DONE.
REQ-025 In REQ, if bus_ack stays 0 for MAX_WAIT cycles, the FSM SHALL drop bus_req and enter ERR; load_data is then 0.
REQ-026 DONE and ERR SHALL last exactly one cycle, assert done=1, and return to IDLE.
REQ-027 mem_err SHALL be 1 in ERR only.
REQ-028 stall SHALL equal (mem_re|mem_we) & ~done.
REQ-029 Minimum latency SHALL be 3 cycles (IDLE, REQ with ack, DONE), giving 2 stall cycles.
REQ-030 A back-to-back access SHALL start in the IDLE cycle after DONE.
REQ-031 Byte enables SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-032 bus_wdata SHALL be {4{wdata[7:0]}} for a byte, {2{wdata[15:0]}} for a half, and wdata for a word.
REQ-033 A load SHALL select the byte or half lane by addr[1:0] and extend it to 32 bits per mem_signed.
REQ-034 bus_we SHALL equal mem_we latched on entry to REQ.
REQ-035 The wait counter SHALL saturate and clear on entry to REQ.

Reset
REQ-036 When reset=1 at a posedge, the block SHALL go to IDLE and set bus_req, bus_we, bus_addr, bus_be, bus_wdata, load_data and the wait counter to 0.
REQ-037 A reset during REQ SHALL abandon the access; bus_req is 0 in the next cycle and no done pulse occurs.
REQ-038 After reset, done and mem_err SHALL be 0; stall follows REQ-028.

Configuration
REQ-039 Macro ALIGN_CHECK_EN SHALL control the alignment check.
REQ-040 With ALIGN_CHECK_EN defined, a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL go from IDLE directly to ERR with no bus_req.
REQ-041 Without ALIGN_CHECK_EN, such accesses SHALL proceed with the offending low address bits treated as 0, and mem_err SHALL come only from a timeout.

Verification
REQ-042 lw addr=0x0000_1004, ack on the first REQ cycle, rdata=0xDEADBEEF -> bus_be=4'hF; done at cycle 3; load_data=0xDEADBEEF; stall high for 2 cycles.
REQ-043 sb addr=0x0000_2003, wdata=0x0000_00A5 -> bus_be=4'b1000, bus_wdata=0xA5A5A5A5, bus_we=1; signals hold through 3 cycles of ack=0.
REQ-044 lh signed addr=0x0000_3002, rdata=0x8001_1234 -> load_data=0xFFFF8001; lhu at the same address gives 0x00008001.
REQ-045 lw with ack never asserted, MAX_WAIT=15 -> bus_req high for 15 cycles, then ERR with done=1, mem_err=1, load_data=0.
REQ-046 reset=1 in the second REQ cycle -> next cycle bus_req=0, state IDLE, no done pulse.
REQ-047 sw addr=0x0000_0006 -> with ALIGN_CHECK_EN: mem_err=1 and no bus_req; without it: bus_addr=0x0000_0004, be=4'hF.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bundle of the M-stage request, memory bus and completion signals of the
// memory access unit. The slave modport is the unit itself; the master
// modport is its environment (pipeline plus memory).
interface mem_access_unit_if;
    // pipeline request
    logic        mem_re;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    // memory bus
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    // completion
    logic [31:0] load_data;
    logic        done;
    logic        stall;
    logic        mem_err;

    modport slave (
        input  mem_re, mem_we, mem_size, mem_signed, mem_addr, mem_wdata,
        input  bus_ack, bus_rdata,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output load_data, done, stall, mem_err
    );

    modport master (
        output mem_re, mem_we, mem_size, mem_signed, mem_addr, mem_wdata,
        output bus_ack, bus_rdata,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  load_data, done, stall, mem_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit for the M stage: turns a load/store request into a
// registered single-beat bus transaction, stalls the pipeline until it
// completes, and returns the aligned, extended load result.
// Optional build macro ALIGN_CHECK_EN: misaligned half/word accesses are
// rejected with mem_err instead of being issued with the low bits dropped.
module mem_access_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.slave   mau
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t             state_q, state_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_we_q, bus_we_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [3:0]         bus_be_q, bus_be_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    logic [31:0]        load_data_q, load_data_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]         lane_q, lane_d;
    logic [1:0]         size_q, size_d;
    logic               sgn_q, sgn_d;

    logic               access;
    logic [1:0]         size_n;
    logic [1:0]         lane_n;
    logic [3:0]         be_n;
    logic [31:0]        wdata_n;
    logic               misaligned;
    logic [31:0]        rd_shift;
    logic [31:0]        ld_ext;

    assign access = mau.mem_re | mau.mem_we;

    // Decode size, effective lane offset, byte enables and replicated store data
    always_comb begin
        size_n  = (mau.mem_size == 2'd3) ? 2'd2 : mau.mem_size;
        lane_n  = 2'b00;
        be_n    = 4'b1111;
        wdata_n = mau.mem_wdata;
        case (size_n)
            2'd0: begin
                lane_n  = mau.mem_addr[1:0];
                be_n    = 4'b0001 << mau.mem_addr[1:0];
                wdata_n = {4{mau.mem_wdata[7:0]}};
            end
            2'd1: begin
                lane_n  = {mau.mem_addr[1], 1'b0};
                be_n    = 4'b0011 << {mau.mem_addr[1], 1'b0};
                wdata_n = {2{mau.mem_wdata[15:0]}};
            end
            default: begin
                lane_n  = 2'b00;
                be_n    = 4'b1111;
                wdata_n = mau.mem_wdata;
            end
        endcase
`ifdef ALIGN_CHECK_EN
        misaligned = ((size_n == 2'd1) && mau.mem_addr[0]) ||
                     ((size_n == 2'd2) && (mau.mem_addr[1:0] != 2'b00));
`else
        // low address bits are simply ignored for half/word accesses
        misaligned = 1'b0;
`endif
    end

    // Select the addressed lane of the read word and sign/zero extend it
    always_comb begin
        rd_shift = mau.bus_rdata >> {lane_q, 3'b000};
        case (size_q)
            2'd0:    ld_ext = {{24{sgn_q & rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    ld_ext = {{16{sgn_q & rd_shift[15]}}, rd_shift[15:0]};
            default: ld_ext = mau.bus_rdata;
        endcase
    end

    // Next-state and bus register update
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        load_data_d = load_data_q;
        wait_cnt_d  = wait_cnt_q;
        lane_d      = lane_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        load_data_d = 32'd0;
                        state_d     = ERR;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = mau.mem_we;
                        bus_addr_d  = {mau.mem_addr[31:2], 2'b00};
                        bus_be_d    = be_n;
                        bus_wdata_d = wdata_n;
                        wait_cnt_d  = '0;
                        lane_d      = lane_n;
                        size_d      = size_n;
                        sgn_d       = mau.mem_signed;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                if (mau.bus_ack) begin
                    bus_req_d   = 1'b0;
                    load_data_d = ld_ext;
                    state_d     = DONE;
                end else if (wait_cnt_q >= CNT_W'(MAX_WAIT - 1)) begin
                    // this was the last allowed unacknowledged cycle
                    bus_req_d   = 1'b0;
                    load_data_d = 32'd0;
                    state_d     = ERR;
                end else if (wait_cnt_q != CNT_W'(MAX_WAIT)) begin
                    wait_cnt_d  = wait_cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and bus registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            load_data_q <= 32'd0;
            wait_cnt_q  <= '0;
            lane_q      <= 2'd0;
            size_q      <= 2'd0;
            sgn_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            load_data_q <= load_data_d;
            wait_cnt_q  <= wait_cnt_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
        end
    end

    assign mau.bus_req   = bus_req_q;
    assign mau.bus_we    = bus_we_q;
    assign mau.bus_addr  = bus_addr_q;
    assign mau.bus_be    = bus_be_q;
    assign mau.bus_wdata = bus_wdata_q;
    assign mau.load_data = load_data_q;
    assign mau.done      = (state_q == DONE) || (state_q == ERR);
    assign mau.mem_err   = (state_q == ERR);
    assign mau.stall     = access & ~mau.done;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the stimulus pushes expected
// completions, a negedge monitor pops and compares them on every done pulse.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if ifc();

    mem_access_unit #(.MAX_WAIT(15)) dut (
        .clk   (clk),
        .reset (rst),
        .mau   (ifc)
    );

    typedef struct {
        logic [31:0] ld;
        logic        chk_ld;
        logic        err;
        int          stall;
        int          req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // memory responder configuration
    int          ack_delay = 0;
    logic [31:0] rd_word   = 32'd0;
    int          resp_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Memory model: acks after ack_delay unacknowledged REQ cycles
    always @(negedge clk) begin
        if (ifc.bus_req) begin
            ifc.bus_ack   = (resp_cnt == ack_delay);
            ifc.bus_rdata = rd_word;
            resp_cnt++;
        end else begin
            ifc.bus_ack   = 1'b0;
            ifc.bus_rdata = 32'd0;
            resp_cnt      = 0;
        end
    end

    // Monitor: bus request fields, hold stability, stall/req counts, completion
    logic        prev_req = 1'b0;
    logic        hold_bad = 1'b0;
    int          stall_cnt = 0;
    int          req_cnt = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_req  = 1'b0;
            hold_bad  = 1'b0;
            stall_cnt = 0;
            req_cnt   = 0;
        end else begin
            if (ifc.stall) stall_cnt++;
            if (ifc.bus_req) begin
                req_cnt++;
                if (!prev_req) begin
                    cap_addr  = ifc.bus_addr;
                    cap_be    = ifc.bus_be;
                    cap_wdata = ifc.bus_wdata;
                    cap_we    = ifc.bus_we;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_bus_req: got 1 expected 0");
                    end else begin
                        chk("bus_addr",  ifc.bus_addr,  exp_q[0].addr);
                        chk("bus_be",    {28'd0, ifc.bus_be}, {28'd0, exp_q[0].be});
                        chk("bus_wdata", ifc.bus_wdata, exp_q[0].wdata);
                        chk("bus_we",    {31'd0, ifc.bus_we}, {31'd0, exp_q[0].we});
                    end
                end else if (ifc.bus_addr !== cap_addr || ifc.bus_be !== cap_be ||
                             ifc.bus_wdata !== cap_wdata || ifc.bus_we !== cap_we) begin
                    hold_bad = 1'b1;
                end
            end
            if (ifc.done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got 1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_ld) chk("load_data", ifc.load_data, e.ld);
                    chk("mem_err",     {31'd0, ifc.mem_err}, {31'd0, e.err});
                    chk("stall_cycles", stall_cnt, e.stall);
                    chk("req_cycles",   req_cnt,   e.req);
                    chk("bus_hold",    {31'd0, hold_bad}, 32'd0);
                end
                stall_cnt = 0;
                req_cnt   = 0;
                hold_bad  = 1'b0;
            end
            prev_req = ifc.bus_req;
        end
    end

    task automatic clear_inputs();
        ifc.mem_re     = 1'b0;
        ifc.mem_we     = 1'b0;
        ifc.mem_size   = 2'd0;
        ifc.mem_signed = 1'b0;
        ifc.mem_addr   = 32'd0;
        ifc.mem_wdata  = 32'd0;
    endtask

    // Called just after a posedge; returns just after a posedge with inputs cleared
    task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int delay,
                          input logic [31:0] x_ld, input logic x_chk, input logic x_err,
                          input int x_stall, input int x_req, input logic [31:0] x_addr,
                          input logic [3:0] x_be, input logic [31:0] x_wdata);
        exp_t e;
        bit   seen = 0;
        e.ld = x_ld; e.chk_ld = x_chk; e.err = x_err; e.stall = x_stall; e.req = x_req;
        e.addr = x_addr; e.be = x_be; e.wdata = x_wdata; e.we = we;
        exp_q.push_back(e);
        ack_delay      = delay;
        rd_word        = rdata;
        ifc.mem_re     = ~we;
        ifc.mem_we     = we;
        ifc.mem_size   = size;
        ifc.mem_signed = sgn;
        ifc.mem_addr   = addr;
        ifc.mem_wdata  = wdata;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.done) begin seen = 1; break; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: got 0 expected 1 at 0x%08h", addr);
            void'(exp_q.pop_front());
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        ifc.bus_ack   = 1'b0;
        ifc.bus_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req",   {31'd0, ifc.bus_req}, 32'd0);
        chk("rst_bus_we",    {31'd0, ifc.bus_we},  32'd0);
        chk("rst_bus_addr",  ifc.bus_addr,  32'd0);
        chk("rst_bus_be",    {28'd0, ifc.bus_be}, 32'd0);
        chk("rst_bus_wdata", ifc.bus_wdata, 32'd0);
        chk("rst_load_data", ifc.load_data, 32'd0);
        chk("rst_done",      {31'd0, ifc.done},    32'd0);
        chk("rst_mem_err",   {31'd0, ifc.mem_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // lw, ack on first REQ cycle
        access(0, 2'd2, 0, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 0,
               32'hDEAD_BEEF, 1, 0, 2, 1, 32'h0000_1004, 4'hF, 32'd0);
        // sb to lane 3, three unacknowledged cycles
        access(1, 2'd0, 0, 32'h0000_2003, 32'h0000_00A5, 32'd0, 3,
               32'd0, 0, 0, 5, 4, 32'h0000_2000, 4'b1000, 32'hA5A5_A5A5);
        // lh then lhu back to back, upper half
        access(0, 2'd1, 1, 32'h0000_3002, 32'd0, 32'h8001_1234, 0,
               32'hFFFF_8001, 1, 0, 2, 1, 32'h0000_3000, 4'b1100, 32'd0);
        access(0, 2'd1, 0, 32'h0000_3002, 32'd0, 32'h8001_1234, 0,
               32'h0000_8001, 1, 0, 2, 1, 32'h0000_3000, 4'b1100, 32'd0);
        // lb signed lane 1, lbu lane 3
        access(0, 2'd0, 1, 32'h0000_2001, 32'd0, 32'h0000_8000, 1,
               32'hFFFF_FF80, 1, 0, 3, 2, 32'h0000_2000, 4'b0010, 32'd0);
        access(0, 2'd0, 0, 32'h0000_2003, 32'd0, 32'h7F00_0000, 0,
               32'h0000_007F, 1, 0, 2, 1, 32'h0000_2000, 4'b1000, 32'd0);
        // sh lower/upper lane replication
        access(1, 2'd1, 0, 32'h0000_2002, 32'h1234_BEEF, 32'd0, 0,
               32'd0, 0, 0, 2, 1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
        // size 3 behaves as word
        access(0, 2'd3, 1, 32'h0000_0010, 32'd0, 32'h1122_3344, 0,
               32'h1122_3344, 1, 0, 2, 1, 32'h0000_0010, 4'hF, 32'd0);
        @(posedge clk); #1;
        // lw that is never acknowledged: 15 REQ cycles then ERR
        access(0, 2'd2, 0, 32'h0000_0040, 32'd0, 32'hFFFF_FFFF, 1000,
               32'd0, 1, 1, 16, 15, 32'h0000_0040, 4'hF, 32'd0);
        @(posedge clk); #1;
        // misaligned sw
`ifdef ALIGN_CHECK_EN
        access(1, 2'd2, 0, 32'h0000_0006, 32'h1234_5678, 32'd0, 0,
               32'd0, 1, 1, 1, 0, 32'd0, 4'h0, 32'd0);
`else
        access(1, 2'd2, 0, 32'h0000_0006, 32'h1234_5678, 32'd0, 0,
               32'd0, 0, 0, 2, 1, 32'h0000_0004, 4'hF, 32'h1234_5678);
`endif
        @(posedge clk); #1;

        // reset in the second REQ cycle abandons the access
        ack_delay      = 1000;
        ifc.mem_re     = 1'b1;
        ifc.mem_size   = 2'd2;
        ifc.mem_addr   = 32'h0000_0080;
        exp_q.push_back('{ld: 32'd0, chk_ld: 1'b0, err: 1'b0, stall: 0, req: 0,
                          addr: 32'h0000_0080, be: 4'hF, wdata: 32'd0, we: 1'b0});
        @(posedge clk); #1;     // first REQ cycle
        @(posedge clk); #1;     // second REQ cycle
        rst = 1'b1;
        clear_inputs();
        void'(exp_q.pop_front());
        @(negedge clk);
        chk("rstreq_bus_req_before", {31'd0, ifc.bus_req}, 32'd1);
        @(negedge clk);
        chk("rstreq_bus_req", {31'd0, ifc.bus_req}, 32'd0);
        chk("rstreq_done",    {31'd0, ifc.done},    32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("rstreq_no_done", {31'd0, ifc.done}, 32'd0);
        end
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
